// File: rtl/din_debounce.sv
// rtl/din_debounce.sv - synchronise and debounce a raw level; optional DIN_DEBOUNCE_GLITCH_CNT_EN adds a bounce counter
module din_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_async,
    input  logic       en,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic S_STABLE = 1'b0;
    localparam logic S_FILTER = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q;

    // Synchroniser shift chain; runs regardless of en so the filter sees fresh samples on resume
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], din_async};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Filter next-state: a difference must persist for STABLE_CNT enabled samples before dout follows
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            case (state_q)
                S_STABLE: begin
                    if (sync_q != dout_q) begin
                        state_d = S_FILTER;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                S_FILTER: begin
                    if (sync_q == dout_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        dout_d  = sync_q;
                        rise_d  = sync_q;
                        fall_d  = ~sync_q;
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Filter state, level and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= (state_d == S_FILTER);
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    logic       bounce;
    logic [7:0] glitch_q;

    assign bounce = en && (state_q == S_FILTER) && (sync_q == dout_q);

    // Saturating count of rejected bounces
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else if (bounce && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_din_debounce.sv
// tb/tb_din_debounce.sv - self-checking bench for din_debounce
module tb_din_debounce;

    logic clk = 1'b0;
    logic reset;
    logic din_async;
    logic en;
    logic dout, rise, fall, busy;
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int both_hi = 0;

    din_debounce #(.SYNC_STAGES(2), .STABLE_CNT(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .din_async (din_async),
        .en        (en),
        .dout      (dout),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int pulse_len;
        int frz_start;
        int frz_len;
        int exp_rise_edge;
        int exp_busy_edge;
        int exp_glitch;
    } vec_t;

    typedef struct {
        int rise_edge;
        int rise_cnt;
        int busy_edge;
        int glitch;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; din_async = 1'b0; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Drive din_async high on edges 1..pulse (edge 1 = E0), low afterwards; en low on frozen edges.
    task automatic measure(input int pulse, input int fs, input int fl, input int n_edges,
                           output int rise_e, output int rise_n, output int fall_e,
                           output int fall_n, output int busy_e, output int busy7);
        rise_e = 0; rise_n = 0; fall_e = 0; fall_n = 0; busy_e = 0; busy7 = 0;
        for (int e = 1; e <= n_edges; e++) begin
            @(negedge clk);
            din_async = (e <= pulse);
            en        = !(e >= fs && e < fs + fl);
            @(posedge clk);
            #1;
            if (rise) begin rise_n++; if (rise_e == 0) rise_e = e; end
            if (fall) begin fall_n++; if (fall_e == 0) fall_e = e; end
            if (busy && busy_e == 0) busy_e = e;
            if (e == 7) busy7 = busy;
            if (rise && fall) both_hi++;
        end
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        int re, rn, fe, fn, be, b7;
        exp_t got, want;
        logic prev;
        int changes;

        vecs[0] = '{3,   0, 0, 0,  3, 1};
        vecs[1] = '{7,   0, 0, 0,  3, 1};
        vecs[2] = '{8,   0, 0, 10, 3, 0};
        vecs[3] = '{100, 0, 0, 10, 3, 0};
        vecs[4] = '{100, 5, 5, 15, 3, 0};
        vecs[5] = '{8,   5, 5, 0,  3, 1};
        vecs[6] = '{100, 1, 3, 11, 4, 0};

        // reset held for 3 edges with din_async high
        reset = 1'b1; din_async = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_outputs_edge%0d", i), int'({dout, rise, fall, busy}), 0);
        end

        // table-driven pulse/freeze vectors through the scoreboard
        for (int r = 0; r < 7; r++) begin
            do_reset();
            want.rise_edge = vecs[r].exp_rise_edge;
            want.rise_cnt  = (vecs[r].exp_rise_edge != 0) ? 1 : 0;
            want.busy_edge = vecs[r].exp_busy_edge;
            want.glitch    = vecs[r].exp_glitch;
            sb.push_back(want);
            measure(vecs[r].pulse_len, vecs[r].frz_start, vecs[r].frz_len, 30,
                    re, rn, fe, fn, be, b7);
            got.rise_edge = re;
            got.rise_cnt  = rn;
            got.busy_edge = be;
            got.glitch    = 0;
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
            got.glitch    = int'(glitch_cnt);
`endif
            want = sb.pop_front();
            check($sformatf("vec%0d_rise_edge", r), got.rise_edge, want.rise_edge);
            check($sformatf("vec%0d_rise_count", r), got.rise_cnt, want.rise_cnt);
            check($sformatf("vec%0d_busy_edge", r), got.busy_edge, want.busy_edge);
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
            check($sformatf("vec%0d_glitch_cnt", r), got.glitch, want.glitch);
`endif
        end

        // input toggling every cycle never moves dout
        do_reset();
        changes = 0;
        prev = dout;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            din_async = e[0];
            @(posedge clk);
            #1;
            if (dout !== prev || rise || fall) changes++;
            prev = dout;
        end
        check("toggle_no_change", changes, 0);
        check("toggle_dout", int'(dout), 0);

        // clean fall, then fall with en frozen for 5 cycles mid-filter
        do_reset();
        measure(100, 0, 0, 12, re, rn, fe, fn, be, b7);
        check("pre_fall_dout", int'(dout), 1);
        measure(0, 0, 0, 20, re, rn, fe, fn, be, b7);
        check("fall_edge", fe, 10);
        check("fall_count", fn, 1);
        check("fall_no_rise", rn, 0);
        measure(100, 0, 0, 12, re, rn, fe, fn, be, b7);
        check("rerise_edge", re, 10);
        measure(0, 5, 5, 25, re, rn, fe, fn, be, b7);
        check("frozen_fall_edge", fe, 15);
        check("frozen_busy_held", b7, 1);
        check("frozen_fall_dout", int'(dout), 0);

        // reset asserted for one edge mid-filter discards the partial count
        do_reset();
        re = 0;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk);
            din_async = 1'b1;
            reset     = (e == 8);
            en        = 1'b1;
            @(posedge clk);
            #1;
            if (e == 7) check("midfilter_busy_before_reset", int'(busy), 1);
            if (e == 8) check("midfilter_after_reset", int'({dout, busy, rise, fall}), 0);
            if (rise && re == 0) re = e;
        end
        @(negedge clk);
        reset = 1'b0;
        check("midfilter_rise_edge", re, 18);
        check("midfilter_dout", int'(dout), 1);

        check("rise_fall_exclusive", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
